// File: rtl/ita_step_scheduler.sv
// Tile sequencer for the ITA attention datapath: walks each head through Q, K, V, QK, AV, OW,
// issuing one tile per handshake and draining in-flight tiles before each dependent step.
module ita_step_scheduler #(
  parameter int unsigned H              = 1,
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned TileW          = 32,
  localparam int unsigned NHeadsW = (H + 1 > 1) ? $clog2(H + 1) : 1,
  localparam int unsigned HeadW   = (H > 1) ? $clog2(H) : 1,
  localparam int unsigned OutW    = (MaxOutstanding + 1 > 1) ? $clog2(MaxOutstanding + 1) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [NHeadsW-1:0] n_heads_i,
  input  logic [TileW-1:0]   lin_tiles_i,
  input  logic [TileW-1:0]   attn_tiles_i,
  output logic               tile_valid_o,
  input  logic               tile_ready_i,
  output logic [2:0]         step_o,
  output logic [HeadW-1:0]   head_o,
  output logic [TileW-1:0]   tile_idx_o,
  output logic               first_tile_o,
  output logic               last_tile_o,
  input  logic               tile_done_i,
  output logic [OutW-1:0]    outstanding_o,
  output logic               busy_o,
  output logic               done_o,
  output logic               err_o
);

  typedef enum logic [1:0] {Idle, Issue, Drain, Finish} state_e;
  typedef enum logic [2:0] {StQ, StK, StV, StQk, StAv, StOw, StIdle} step_e;

  state_e             state_q, state_n;
  step_e              step_q, step_n;
  logic [HeadW-1:0]   head_q, head_n;
  logic [TileW-1:0]   issued_q, issued_n;
  logic [OutW-1:0]    outst_q, outst_n;
  logic [NHeadsW-1:0] nheads_q, nheads_n;
  logic [TileW-1:0]   lin_q, lin_n, attn_q, attn_n;
  logic [TileW-1:0]   tiles_cur, tiles_nxt;
  logic               valid_q, valid_n, first_q, first_n, last_q, last_n;
  logic               busy_q, busy_n, done_q, done_n, err_q, err_n;
  logic               hs, last_head;

  function automatic logic [TileW-1:0] tiles_of(step_e s, logic [TileW-1:0] lin,
                                                logic [TileW-1:0] attn);
    return (s == StQk || s == StAv) ? attn : lin;
  endfunction

  assign hs        = valid_q & tile_ready_i;
  assign tiles_cur = tiles_of(step_q, lin_q, attn_q);
  assign last_head = (NHeadsW'(head_q) + NHeadsW'(1)) == nheads_q;

  // Next-state, counters and the values the registered outputs will take
  always_comb begin
    state_n  = state_q;
    step_n   = step_q;
    head_n   = head_q;
    issued_n = issued_q;
    nheads_n = nheads_q;
    lin_n    = lin_q;
    attn_n   = attn_q;
    busy_n   = busy_q;
    done_n   = 1'b0;
    outst_n  = outst_q;
    if (hs && !tile_done_i) begin
      outst_n = outst_q + OutW'(1);
    end else if (!hs && tile_done_i && outst_q != '0) begin
      outst_n = outst_q - OutW'(1);
    end
    err_n = err_q | (tile_done_i & ~hs & (outst_q == '0));

    unique case (state_q)
      Idle: begin
        busy_n = 1'b0;
        if (start_i) begin
          nheads_n = n_heads_i;
          lin_n    = lin_tiles_i;
          attn_n   = attn_tiles_i;
          err_n    = 1'b0;
          head_n   = '0;
          step_n   = StQ;
          issued_n = '0;
          busy_n   = 1'b1;
          state_n  = (n_heads_i == '0) ? Finish : Issue;
        end
      end
      Issue: begin
        issued_n = issued_q + TileW'(hs);
        if (issued_n == tiles_cur) state_n = Drain;
      end
      Drain: begin
        // The next-value count lets a completion arriving this cycle release the barrier
        if (outst_n == '0) begin
          issued_n = '0;
          if (step_q != StOw) begin
            step_n  = step_e'(step_q + 3'd1);
            state_n = Issue;
          end else if (last_head) begin
            state_n = Finish;
          end else begin
            head_n  = head_q + HeadW'(1);
            step_n  = StQ;
            state_n = Issue;
          end
        end
      end
      Finish: begin
        done_n  = 1'b1;
        step_n  = StIdle;
        state_n = Idle;
      end
      default: state_n = Idle;
    endcase

    tiles_nxt = tiles_of(step_n, lin_n, attn_n);
    valid_n   = (state_n == Issue) && (issued_n < tiles_nxt) &&
                (outst_n < OutW'(MaxOutstanding));
    first_n   = valid_n && (issued_n == '0);
    last_n    = valid_n && (issued_n == tiles_nxt - TileW'(1));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= Idle;
      step_q   <= StIdle;
      head_q   <= '0;
      issued_q <= '0;
      outst_q  <= '0;
      nheads_q <= '0;
      lin_q    <= '0;
      attn_q   <= '0;
      valid_q  <= 1'b0;
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      step_q   <= step_n;
      head_q   <= head_n;
      issued_q <= issued_n;
      outst_q  <= outst_n;
      nheads_q <= nheads_n;
      lin_q    <= lin_n;
      attn_q   <= attn_n;
      valid_q  <= valid_n;
      first_q  <= first_n;
      last_q   <= last_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      err_q    <= err_n;
    end
  end

  assign tile_valid_o  = valid_q;
  assign step_o        = step_q;
  assign head_o        = head_q;
  assign tile_idx_o    = issued_q;
  assign first_tile_o  = first_q;
  assign last_tile_o   = last_q;
  assign outstanding_o = outst_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_ita_step_scheduler.sv
// Bench for ita_step_scheduler: table of randomized runs checked against a tile-order model,
// plus directed sequences for backpressure, outstanding cap, zero heads, errors and abort.
module tb_ita_step_scheduler;
  localparam int unsigned MaxOut = 8;

  logic        clk = 1'b0;
  logic        rst, start, ready, done_in;
  logic [1:0]  n_heads;
  logic [31:0] lin, attn;
  logic        tile_valid, first_tile, last_tile, busy, done, err;
  logic [2:0]  step;
  logic [0:0]  head;
  logic [31:0] tile_idx;
  logic [3:0]  outstanding;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int h; int s; int idx; bit first; bit last;
  } tile_t;

  typedef struct {
    int nh; int lin; int attn; int ready_pct; int dmin; int dmax; bit poke; int exp_hs;
  } vec_t;

  always #5 clk = ~clk;

  ita_step_scheduler #(.H(2), .MaxOutstanding(MaxOut), .TileW(32)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .n_heads_i(n_heads),
    .lin_tiles_i(lin), .attn_tiles_i(attn), .tile_valid_o(tile_valid),
    .tile_ready_i(ready), .step_o(step), .head_o(head), .tile_idx_o(tile_idx),
    .first_tile_o(first_tile), .last_tile_o(last_tile), .tile_done_i(done_in),
    .outstanding_o(outstanding), .busy_o(busy), .done_o(done), .err_o(err)
  );

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"}, tile_valid, 0);
    check({tag, "_step"}, step, 6);
    check({tag, "_head"}, head, 0);
    check({tag, "_idx"}, tile_idx, 0);
    check({tag, "_first"}, first_tile, 0);
    check({tag, "_last"}, last_tile, 0);
    check({tag, "_outstanding"}, outstanding, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // One complete run; the expected tile order is built straight from heads x steps x tiles
  task automatic run_vec(input vec_t v, output int hs_seen);
    tile_t       expq[$];
    tile_t       e;
    int          due[$];
    int          model_out, cyc, last_due, t, d;
    bit          pv, pr, pd, pfirst, plast, finished;
    logic [2:0]  pstep;
    logic [0:0]  phead;
    logic [31:0] pidx;
    for (int h = 0; h < v.nh; h++) begin
      for (int s = 0; s < 6; s++) begin
        t = (s == 3 || s == 4) ? v.attn : v.lin;
        for (int i = 0; i < t; i++) expq.push_back('{h, s, i, i == 0, i == t - 1});
      end
    end
    hs_seen = 0; model_out = 0; cyc = 0; last_due = 0; finished = 0;
    pv = 0; pr = 0; pd = 0; pfirst = 0; plast = 0; pstep = 0; phead = 0; pidx = 0;
    start = 1; n_heads = 2'(v.nh); lin = v.lin; attn = v.attn; ready = 0; done_in = 0;
    tick();
    start = 0; n_heads = 2'($urandom); lin = $urandom; attn = $urandom;
    check("busy_after_start", busy, 1);
    check("err_cleared_by_start", err, 0);
    for (int c = 0; c < 4000 && !finished; c++) begin
      cyc++;
      if (pv && pr) begin
        hs_seen++;
        if (expq.size() == 0) begin
          check("unexpected_handshake", 1, 0);
        end else begin
          e = expq.pop_front();
          check("hs_head", phead, e.h);
          check("hs_step", pstep, e.s);
          check("hs_idx", pidx, e.idx);
          check("hs_first", pfirst, e.first);
          check("hs_last", plast, e.last);
        end
        d = $urandom_range(v.dmax, v.dmin);
        last_due = (cyc + d > last_due + 1) ? cyc + d : last_due + 1;
        due.push_back(last_due);
      end
      model_out = model_out + ((pv && pr) ? 1 : 0) - (pd ? 1 : 0);
      check("outstanding", outstanding, model_out);
      if (outstanding > 4'(MaxOut)) check("outstanding_cap", outstanding, MaxOut);
      if (pv && !pr) begin
        check("stall_valid_held", tile_valid, 1);
        check("stall_step_held", step, pstep);
        check("stall_head_held", head, phead);
        check("stall_idx_held", tile_idx, pidx);
      end
      if (done) begin
        finished = 1;
      end else begin
        pv = tile_valid; pstep = step; phead = head; pidx = tile_idx;
        pfirst = first_tile; plast = last_tile;
        ready = ($urandom_range(0, 99) < v.ready_pct);
        done_in = (due.size() > 0 && due[0] <= cyc);
        if (done_in) void'(due.pop_front());
        start = v.poke && ($urandom_range(0, 29) == 0);
        pr = ready; pd = done_in;
        tick();
      end
    end
    start = 0; ready = 0; done_in = 0;
    if (!finished) check("run_timeout", 0, 1);
    check("all_tiles_issued", expq.size(), 0);
    check("end_outstanding", outstanding, 0);
    check("end_step_idle", step, 6);
    check("end_err", err, 0);
    tick();
    check("done_single_pulse", done, 0);
    check("busy_low_after_done", busy, 0);
  endtask

  initial begin
    vec_t vecs[7];
    int   hs;
    int   cnt;
    vecs[0] = '{1, 2, 3, 100, 2, 2, 1'b0, 14};
    vecs[1] = '{2, 3, 0, 70, 1, 5, 1'b1, 24};
    vecs[2] = '{1, 12, 1, 60, 1, 20, 1'b0, 50};
    vecs[3] = '{2, 1, 2, 50, 1, 3, 1'b1, 16};
    vecs[4] = '{1, 0, 4, 80, 1, 4, 1'b0, 8};
    vecs[5] = '{2, 5, 7, 90, 1, 10, 1'b1, 68};
    vecs[6] = '{1, 1, 1, 100, 1, 1, 1'b0, 6};

    rst = 1; start = 0; n_heads = 0; lin = 0; attn = 0; ready = 0; done_in = 0;
    tick(); tick();
    check_reset("por");
    rst = 0;

    // Spurious completion in idle
    done_in = 1; tick(); done_in = 0;
    check("err_spurious_idle", err, 1);
    check("outstanding_saturated", outstanding, 0);
    tick();
    check("err_sticky", err, 1);

    // Zero heads: done two cycles after start, nothing issued
    start = 1; n_heads = 0; lin = 5; attn = 5; tick(); start = 0;
    check("nh0_busy", busy, 1);
    check("nh0_err_cleared", err, 0);
    check("nh0_done_early", done, 0);
    check("nh0_valid", tile_valid, 0);
    tick();
    check("nh0_done", done, 1);
    check("nh0_valid2", tile_valid, 0);
    tick();
    check("nh0_done_pulse", done, 0);
    check("nh0_busy_low", busy, 0);

    // Backpressure: Q drains only once its four tiles complete
    start = 1; n_heads = 1; lin = 4; attn = 1; ready = 1; tick(); start = 0;
    repeat (20) tick();
    check("bp_outstanding", outstanding, 4);
    check("bp_step_q", step, 0);
    check("bp_valid", tile_valid, 0);
    done_in = 1;
    repeat (3) tick();
    check("bp_still_q", step, 0);
    check("bp_out1", outstanding, 1);
    tick();
    done_in = 0;
    check("bp_out0", outstanding, 0);
    check("bp_step_k", step, 1);

    // Run on to AV, then abort with reset
    for (int c = 0; c < 300 && step != 3'd4; c++) begin
      done_in = (outstanding != 0);
      tick();
    end
    done_in = 0;
    check("reach_av", step, 4);
    rst = 1; tick(); rst = 0; ready = 0;
    check_reset("abort_av");

    // Outstanding cap, then simultaneous handshake and completion
    start = 1; n_heads = 1; lin = 12; attn = 1; ready = 1; tick(); start = 0;
    cnt = 0;
    repeat (20) begin
      if (tile_valid) cnt++;
      tick();
    end
    check("cap_handshakes", cnt, 8);
    check("cap_outstanding", outstanding, 8);
    check("cap_valid_low", tile_valid, 0);
    check("cap_idx", tile_idx, 8);
    done_in = 1; tick();
    check("cap_out_dec", outstanding, 7);
    check("cap_valid_back", tile_valid, 1);
    tick();
    done_in = 0;
    check("cap_out_const", outstanding, 7);
    check("cap_idx9", tile_idx, 9);
    check("cap_step", step, 0);
    rst = 1; tick(); rst = 0; ready = 0;
    check_reset("abort_cap");

    for (int k = 0; k < 7; k++) begin
      run_vec(vecs[k], hs);
      check($sformatf("hs_count_v%0d", k), hs, vecs[k].exp_hs);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d failed so far", fails);
    $fatal(1, "watchdog");
  end

endmodule
